dsp_result_display: RTL and testbench

Downstream display stage for the 3-tap DSP multiply-accumulate chain. It captures the chain's 8-bit result on a sample strobe and converts it to three BCD digits with a sequential double-dabble converter. It then drives a 4-digit common-anode seven-segment display through time-multiplexing, with leading-zero blanking. Samples that arrive while a conversion is in flight are dropped and counted.

---
 rtl/dsp_result_display_pkg.sv | 46 ++++
 rtl/dsp_result_display_bin8_to_bcd3.sv | 79 +++++++
 rtl/dsp_result_display.sv | 97 +++++++++
 tb/tb_dsp_result_display.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_result_display_pkg.sv
// Shared types and constants for the DSP result display: converter FSM states, segment codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dsp_result_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    localparam int DIGITS = 3;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // BCD nibble to segment pattern; non-decimal codes show blank
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/dsp_result_display_bin8_to_bcd3.sv
// Sequential double-dabble: 8-bit binary to three BCD digits, one shift step per cycle.
// Latency: accept edge + 8 conversion edges + 1 commit edge (done is high in the commit cycle).
// Backpressure: none; din_valid is ignored unless idle, the caller counts the losses.
module bin8_to_bcd3
    import dsp_result_display_pkg::*;
(
    input  logic        clock_pulse,
    input  logic        clr_de_n,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_t state;
    conv_state_t state_nxt;
    logic [7:0]  sh;
    logic [11:0] scratch;
    logic [11:0] adj;
    logic [19:0] shifted;
    logic [2:0]  iter;

    // State register
    always_ff @(posedge clock_pulse or negedge clr_de_n) begin
        if (!clr_de_n) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // Next-state: eight conversion steps, then one commit cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (din_valid) state_nxt = ST_CONV;
            ST_CONV:   if (iter == 3'd7) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would overflow past 9 after the shift
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    assign shifted = {adj, sh} << 1;

    // Shift register, BCD scratch and step counter
    always_ff @(posedge clock_pulse or negedge clr_de_n) begin
        if (!clr_de_n) begin
            sh      <= '0;
            scratch <= '0;
            iter    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (din_valid) begin
                        sh      <= din;
                        scratch <= '0;
                        iter    <= '0;
                    end
                end
                ST_CONV: begin
                    {scratch, sh} <= shifted;
                    iter          <= iter + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_COMMIT);
    assign bcd  = scratch;

endmodule

// File: rtl/dsp_result_display.sv
// Captures DSP results, converts to BCD and scans them onto a 4-digit common-anode display.
// Latency: display registers update 10 edges after accept; seg/an follow within 3 digit slots.
// Backpressure: none; strobes during a conversion are dropped and counted (saturating at 15).
module dsp_result_display
    import dsp_result_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clock_pulse,
    input  logic       clr_de_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [3:0] drop_cnt
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic          conv_done;
    logic [11:0]   conv_bcd;
    logic [3:0]    hund;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic [PW-1:0] prescale;
    logic [1:0]    dsel;
    logic          slot_wrap;
    logic [6:0]    dig_seg;
    logic [3:0]    dig_an;

    bin8_to_bcd3 u_conv (
        .clock_pulse (clock_pulse),
        .clr_de_n    (clr_de_n),
        .din         (din),
        .din_valid   (din_valid),
        .busy        (busy),
        .done        (conv_done),
        .bcd         (conv_bcd)
    );

    // Count strobes that arrive while the converter is occupied, stick at 15
    always_ff @(posedge clock_pulse or negedge clr_de_n) begin
        if (!clr_de_n)                                   drop_cnt <= '0;
        else if (din_valid && busy && drop_cnt != 4'hF)  drop_cnt <= drop_cnt + 4'd1;
    end

    // Latch the finished conversion into the display registers
    always_ff @(posedge clock_pulse or negedge clr_de_n) begin
        if (!clr_de_n) begin
            hund <= '0;
            tens <= '0;
            ones <= '0;
        end else if (conv_done) begin
            {hund, tens, ones} <= conv_bcd;
        end
    end

    assign slot_wrap = (prescale == PW'(REFRESH_DIV - 1));

    // Digit-slot prescaler and digit selector (units, tens, hundreds; an[3] unused)
    always_ff @(posedge clock_pulse or negedge clr_de_n) begin
        if (!clr_de_n) begin
            prescale <= '0;
            dsel     <= '0;
        end else if (slot_wrap) begin
            prescale <= '0;
            dsel     <= (dsel == 2'(DIGITS - 1)) ? 2'd0 : dsel + 2'd1;
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    // Digit mux with leading-zero blanking; the units digit always shows
    always_comb begin
        dig_seg = SEG_BLANK;
        dig_an  = ~(4'b0001 << dsel);
        case (dsel)
            2'd0:    dig_seg = seg_encode(ones);
            2'd1:    dig_seg = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_encode(tens);
            2'd2:    dig_seg = (hund == 4'd0) ? SEG_BLANK : seg_encode(hund);
            default: dig_seg = SEG_BLANK;
        endcase
    end

    // Register seg and an together so a digit never shows half-updated
    always_ff @(posedge clock_pulse or negedge clr_de_n) begin
        if (!clr_de_n) begin
            seg <= SEG_0;
            an  <= 4'b1110;
        end else begin
            seg <= dig_seg;
            an  <= dig_an;
        end
    end

endmodule

// File: tb/tb_dsp_result_display.sv
module tb_dsp_result_display;

    localparam int RD = 4;

    logic       clock_pulse = 1'b0;
    logic       clr_de_n    = 1'b0;
    logic [7:0] din         = 8'd0;
    logic       din_valid   = 1'b0;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;
    logic [3:0] drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: acceptance time line, last accepted value, drop count
    int cyc       = 0;
    int last_acc  = -100;
    int model_val = 0;
    int model_drop = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    dsp_result_display #(.REFRESH_DIV(RD)) dut (
        .clock_pulse (clock_pulse),
        .clr_de_n    (clr_de_n),
        .din         (din),
        .din_valid   (din_valid),
        .busy        (busy),
        .seg         (seg),
        .an          (an),
        .drop_cnt    (drop_cnt)
    );

    always #5 clock_pulse = ~clock_pulse;

    // One clock cycle of stimulus; model: a sample is taken only 10+ cycles after the previous one
    task automatic step(input logic v, input logic [7:0] d);
        din_valid = v;
        din       = d;
        if (v) begin
            if (cyc - last_acc >= 10) begin
                last_acc  = cyc;
                model_val = d;
            end else if (model_drop < 15) begin
                model_drop++;
            end
        end
        cyc++;
        @(negedge clock_pulse);
    endtask

    task automatic model_reset();
        last_acc   = cyc - 100;
        model_val  = 0;
        model_drop = 0;
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        clr_de_n  = 1'b0;
        repeat (2) @(negedge clock_pulse);
        clr_de_n = 1'b1;
        model_reset();
    endtask

    // Let the conversion settle, scan all digit slots and compare with decimal digits of the model value
    task automatic check_display(input string name);
        logic [6:0] got [3];
        bit         seen [3];
        logic [6:0] expv [3];
        for (int i = 0; i < 3; i++) begin
            seen[i] = 1'b0;
            got[i]  = 7'h00;
        end
        repeat (12) step(1'b0, 8'd0);
        repeat (3 * RD + 3) begin
            step(1'b0, 8'd0);
            n_vec++;
            case (an)
                4'b1110: begin got[0] = seg; seen[0] = 1'b1; end
                4'b1101: begin got[1] = seg; seen[1] = 1'b1; end
                4'b1011: begin got[2] = seg; seen[2] = 1'b1; end
                default: begin
                    n_err++;
                    $display("FAIL %s_an: an=%b is not a legal digit enable", name, an);
                end
            endcase
        end
        expv[0] = seg_tab[model_val % 10];
        expv[1] = (model_val < 10)  ? 7'h7F : seg_tab[(model_val / 10) % 10];
        expv[2] = (model_val < 100) ? 7'h7F : seg_tab[model_val / 100];
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (!seen[i] || got[i] !== expv[i]) begin
                n_err++;
                $display("FAIL %s_digit%0d: seg=%h seen=%0d, expected %h (value %0d)",
                         name, i, got[i], seen[i], expv[i], model_val);
            end
        end
        n_vec++;
        if (drop_cnt !== 4'(model_drop)) begin
            n_err++;
            $display("FAIL %s_drop: drop_cnt=%0d, expected %0d", name, drop_cnt, model_drop);
        end
    endtask

    task automatic test_reset();
        din_valid = 1'b0;
        clr_de_n  = 1'b0;
        repeat (20) begin
            @(negedge clock_pulse);
            n_vec++;
            if ({busy, drop_cnt, an, seg} !== {1'b0, 4'd0, 4'b1110, 7'h40}) begin
                n_err++;
                $display("FAIL reset: busy=%b drop=%0d an=%b seg=%h, expected 0 0 1110 40",
                         busy, drop_cnt, an, seg);
            end
        end
        clr_de_n = 1'b1;
        model_reset();
    endtask

    task automatic test_busy_len();
        int n;
        do_reset();
        step(1'b1, 8'd45);
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            n++;
            step(1'b0, 8'd0);
        end
        // busy is seen after edges E0..E8 and has dropped after E9
        n_vec++;
        if (n != 9) begin
            n_err++;
            $display("FAIL busy_len: busy high for %0d cycles, expected 9", n);
        end
        check_display("d45");
    endtask

    task automatic test_values();
        step(1'b1, 8'd255);
        check_display("d255");
        step(1'b1, 8'd7);
        check_display("d7");
    endtask

    task automatic test_drop_pair();
        do_reset();
        step(1'b1, 8'd100);
        step(1'b0, 8'd0);
        step(1'b1, 8'd200);
        check_display("d100_drop200");
    endtask

    task automatic test_e9_e10();
        do_reset();
        step(1'b1, 8'd30);
        repeat (8) step(1'b0, 8'd0);
        step(1'b1, 8'd77);
        n_vec++;
        if (drop_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL e9_drop: drop_cnt=%0d, expected 1", drop_cnt);
        end
        step(1'b1, 8'd123);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL e10_accept: busy=%b, expected 1", busy);
        end
        check_display("e10");
    endtask

    task automatic test_burst();
        do_reset();
        repeat (20) step(1'b1, 8'($urandom_range(0, 255)));
        check_display("burst");
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 8'd45);
        check_display("pre_abort");
        step(1'b1, 8'd99);
        repeat (3) step(1'b0, 8'd0);
        @(posedge clock_pulse);
        #2 clr_de_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, drop_cnt, an, seg} !== {1'b0, 4'd0, 4'b1110, 7'h40}) begin
            n_err++;
            $display("FAIL async_reset: busy=%b drop=%0d an=%b seg=%h, expected 0 0 1110 40",
                     busy, drop_cnt, an, seg);
        end
        repeat (2) @(negedge clock_pulse);
        clr_de_n = 1'b1;
        model_reset();
        check_display("after_abort");
    endtask

    task automatic test_random();
        do_reset();
        for (int r = 0; r < 8; r++) begin
            repeat (25) step(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
            check_display("random");
        end
    endtask

    initial begin
        @(negedge clock_pulse);
        test_reset();
        test_busy_len();
        test_values();
        test_drop_pair();
        test_e9_e10();
        test_burst();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
